// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data memory: RV32I load/store size codes,
// INIT/RUN controller states and the funct3 legality check.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Unsigned sizes exist only for loads; 011/110/111 are never legal.
  function automatic logic is_legal(input logic write, input logic [2:0] funct3);
    case (funct3)
      3'b000, 3'b001, 3'b010: is_legal = 1'b1;
      3'b100, 3'b101:         is_legal = !write;
      default:                is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated store
// data, load extraction with sign/zero extension, and fault detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic        write_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rd_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o,
  output logic        fault_o
);

  logic        misalign;
  logic [31:0] shifted;

  always_comb begin
    misalign = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misalign = lane_i[0];
      2'b10:   misalign = |lane_i;
      default: misalign = 1'b0;
    endcase
    fault_o = misalign || !is_legal(write_i, funct3_i);

    shifted   = rd_word_i >> {lane_i, 3'b000};
    be_o      = 4'h0;
    wdata_o   = st_data_i;
    ld_data_o = 32'h0;
    // Store data is replicated across lanes so the byte enables alone pick the target.
    case (funct3_i[1:0])
      2'b00: begin
        be_o      = 4'b0001 << lane_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{~funct3_i[2] & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be_o      = 4'b0011 << lane_i;
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = {{16{~funct3_i[2] & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o      = 4'hF;
        wdata_o   = st_data_i;
        ld_data_o = rd_word_i;
      end
    endcase
    if (fault_o || !write_i) be_o = 4'h0;
    if (fault_o || write_i) ld_data_o = 32'h0;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-lane data memory with post-reset zeroing sweep and fixed-latency response.
// Define DMEM_STATS_EN to add saturating load/store/fault counters.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LATENCY  = 1,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic              rsp_valid_o,
  output logic [31:0]       data_o,
  output logic              fault_o,
  output logic              init_busy_o,
`ifdef DMEM_STATS_EN
  output logic [31:0]       ld_cnt_o,
  output logic [31:0]       st_cnt_o,
  output logic [31:0]       flt_cnt_o,
`endif
  input  logic [IDX_W-1:0]  dbg_addr_i,
  output logic [31:0]       data_mem_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             init_busy_q, init_busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    init_busy_d = init_busy_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
        state_d     = ST_RUN;
        req_ready_d = 1'b1;
        init_busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign init_busy_o = init_busy_q;

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic             unused_addr_bits;
  logic [31:0]      rd_word;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      ld_data;
  logic             fault;

  assign accept           = req_valid_i & req_ready_q;
  assign idx              = addr_i[IDX_W+1:2];
  assign unused_addr_bits = ^addr_i[31:IDX_W+2];

  dmem_lane_align u_align (
    .lane_i    (addr_i[1:0]),
    .funct3_i  (req_funct3_i),
    .write_i   (req_write_i),
    .st_data_i (data_i),
    .rd_word_i (rd_word),
    .be_o      (be),
    .wdata_o   (wdata),
    .ld_data_o (ld_data),
    .fault_o   (fault)
  );

  // The sweep owns the write port while INIT; afterwards accepted stores do.
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_en;
  logic [31:0]      wr_data;

  always_comb begin
    wr_idx  = idx;
    wr_en   = accept ? be : 4'h0;
    wr_data = wdata;
    if (state_q == ST_INIT) begin
      wr_idx  = cnt_q;
      wr_en   = 4'hF;
      wr_data = 32'h0;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (wr_en[gi]) mem_q[wr_idx] <= wr_data[gi*8 +: 8];
    end

    assign rd_word[gi*8 +: 8]    = mem_q[idx];
    assign data_mem_o[gi*8 +: 8] = mem_q[dbg_addr_i];
  end

  // Data/fault only load alongside a valid, so the last stage holds between pulses.
  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
    logic        in_v, in_f;
    logic [31:0] in_d;
    logic        v_q, v_d, f_q, f_d;
    logic [31:0] d_q, d_d;

    if (gi == 0) begin : g_head
      assign in_v = accept;
      assign in_d = ld_data;
      assign in_f = fault;
    end else begin : g_tail
      assign in_v = g_pipe[gi-1].v_q;
      assign in_d = g_pipe[gi-1].d_q;
      assign in_f = g_pipe[gi-1].f_q;
    end

    always_comb begin
      v_d = in_v;
      d_d = in_v ? in_d : d_q;
      f_d = in_v ? in_f : f_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= 32'h0;
        f_q <= 1'b0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
        f_q <= f_d;
      end
    end
  end

  assign rsp_valid_o = g_pipe[RD_LATENCY-1].v_q;
  assign data_o      = g_pipe[RD_LATENCY-1].d_q;
  assign fault_o     = g_pipe[RD_LATENCY-1].f_q;

`ifdef DMEM_STATS_EN
  logic [31:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d, flt_cnt_q, flt_cnt_d;

  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    st_cnt_d  = st_cnt_q;
    flt_cnt_d = flt_cnt_q;
    if (accept && fault && flt_cnt_q != 32'hFFFF_FFFF) flt_cnt_d = flt_cnt_q + 1'b1;
    if (accept && !fault && req_write_i && st_cnt_q != 32'hFFFF_FFFF) st_cnt_d = st_cnt_q + 1'b1;
    if (accept && !fault && !req_write_i && ld_cnt_q != 32'hFFFF_FFFF) ld_cnt_d = ld_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q  <= 32'h0;
      st_cnt_q  <= 32'h0;
      flt_cnt_q <= 32'h0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      st_cnt_q  <= st_cnt_d;
      flt_cnt_q <= flt_cnt_d;
    end
  end

  assign ld_cnt_o  = ld_cnt_q;
  assign st_cnt_o  = st_cnt_q;
  assign flt_cnt_o = flt_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: INIT timing, sized loads/stores, faults,
// back-to-back store->load, address aliasing and reset with loads in flight.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [2:0]       req_funct3;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             rsp_valid;
  logic [31:0]      rdata;
  logic             fault;
  logic             init_busy;
  logic [IDX_W-1:0] dbg_addr;
  logic [31:0]      dbg_data;
`ifdef DMEM_STATS_EN
  logic [31:0]      ld_cnt, st_cnt, flt_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_funct3_i (req_funct3),
    .addr_i       (addr),
    .data_i       (wdata),
    .rsp_valid_o  (rsp_valid),
    .data_o       (rdata),
    .fault_o      (fault),
    .init_busy_o  (init_busy),
`ifdef DMEM_STATS_EN
    .ld_cnt_o     (ld_cnt),
    .st_cnt_o     (st_cnt),
    .flt_cnt_o    (flt_cnt),
`endif
    .dbg_addr_i   (dbg_addr),
    .data_mem_o   (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int  cyc  = 0;
    bit  seen = 1'b0;
    while (!req_ready && cyc < DEPTH + 8) begin
      tick();
      cyc++;
      if (rsp_valid) seen = 1'b1;
    end
    chk({tag, "/init_cycles"}, cyc, DEPTH);
    chk({tag, "/busy_low"}, init_busy, 1'b0);
    chk({tag, "/no_pulse"}, seen, 1'b0);
    $display("init %s: ready after %0d cycles", tag, cyc);
  endtask

  task automatic dbg(input string tag, input logic [IDX_W-1:0] w, input logic [31:0] exp);
    dbg_addr = w;
    #1;
    chk(tag, dbg_data, exp);
    $display("dbg  %s: word %0d = %h", tag, w, dbg_data);
  endtask

  task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_f);
    chk({tag, "/ready"}, req_ready, 1'b1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    addr       = a;
    wdata      = d;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      chk({tag, "/early"}, rsp_valid, 1'b0);
      tick();
    end
    chk({tag, "/valid"}, rsp_valid, 1'b1);
    chk({tag, "/data"}, rdata, exp_d);
    chk({tag, "/fault"}, fault, exp_f);
    $display("xact %s: w=%0d f3=%b addr=%h data_i=%h -> data_o=%h fault=%0d",
             tag, w, f3, a, d, rdata, fault);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    addr = 32'h0; wdata = 32'h0; dbg_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst/ready", req_ready, 1'b0);
    chk("rst/busy", init_busy, 1'b1);
    chk("rst/rsp_valid", rsp_valid, 1'b0);
    chk("rst/data", rdata, 32'h0);
    chk("rst/fault", fault, 1'b0);
    rst_n = 1'b1;
    wait_ready("por");
    dbg("dbg0", 8'd0, 32'h0);
    dbg("dbg5", 8'd5, 32'h0);
    dbg("dbg_last", 8'(DEPTH - 1), 32'h0);

    // Sized loads of a known word
    xact("sw_beef", 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lb",      1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    xact("lbu",     1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    xact("lh",      1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    xact("lhu",     1'b0, F3_HU, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    xact("lw",      1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    tick();
    chk("hold/valid_low", rsp_valid, 1'b0);
    chk("hold/data", rdata, 32'hDEADBEEF);

    // Partial stores leave other lanes untouched
    xact("sw_base", 1'b1, F3_W, 32'h20, 32'h11223344, 32'h0, 1'b0);
    xact("sb",      1'b1, F3_B, 32'h21, 32'h0000007F, 32'h0, 1'b0);
    dbg("sb_word", 8'd8, 32'h11227F44);
    xact("sh",      1'b1, F3_H, 32'h22, 32'h0000ABCD, 32'h0, 1'b0);
    dbg("sh_word", 8'd8, 32'hABCD7F44);

    // Faults: misaligned and illegal sizes
    xact("sh_mis",  1'b1, F3_H,   32'h11, 32'h0000FFFF, 32'h0, 1'b1);
    xact("sw_mis",  1'b1, F3_W,   32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("ld_011",  1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1);
    xact("st_100",  1'b1, F3_BU,  32'h10, 32'h000000AA, 32'h0, 1'b1);
    dbg("flt_word", 8'd4, 32'hDEADBEEF);

    // Back-to-back store then load of the same word
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; addr = 32'h40; wdata = 32'h1;
    tick();
    req_write = 1'b0; wdata = 32'h0;
    chk("b2b/early", rsp_valid, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("b2b/st_valid", rsp_valid, 1'b1);
    chk("b2b/st_data", rdata, 32'h0);
    chk("b2b/st_fault", fault, 1'b0);
    tick();
    chk("b2b/ld_valid", rsp_valid, 1'b1);
    chk("b2b/ld_data", rdata, 32'h1);
    $display("xact b2b: SW 1 @40 then LW @40 -> data_o=%h", rdata);
    tick();

    // Upper address bits alias onto the same array
    xact("sw_alias", 1'b1, F3_W, 32'(DEPTH * 4 + 32'h40), 32'hCAFEF00D, 32'h0, 1'b0);
    dbg("alias_word", 8'h10, 32'hCAFEF00D);
    xact("lw_alias", 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_STATS_EN
    chk("stats/ld", ld_cnt, 32'd7);
    chk("stats/st", st_cnt, 32'd6);
    chk("stats/flt", flt_cnt, 32'd4);
`endif

    // Reset while loads are being presented and one is in flight
    xact("lw_pre", 1'b0, F3_W, 32'h20, 32'h0, 32'hABCD7F44, 1'b0);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; addr = 32'h10;
    tick();
    addr  = 32'h20;
    rst_n = 1'b0;
    #1;
    chk("mid_rst/valid", rsp_valid, 1'b0);
    chk("mid_rst/data", rdata, 32'h0);
    chk("mid_rst/ready", req_ready, 1'b0);
    chk("mid_rst/busy", init_busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst/no_pulse", rsp_valid, 1'b0);
    end
    req_valid = 1'b0;
`ifdef DMEM_STATS_EN
    chk("mid_rst/ld_cnt", ld_cnt, 32'd0);
    chk("mid_rst/st_cnt", st_cnt, 32'd0);
    chk("mid_rst/flt_cnt", flt_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    wait_ready("rerun");
    xact("lw_cleared", 1'b0, F3_W, 32'h10, 32'h0, 32'h0, 1'b0);
    dbg("cleared_8", 8'd8, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
